// File: rtl/axi3_master_pkg.sv
// axi3_master shared constants and state encodings.
// AXI3 field encodings used by the request-bus bridge.
package axi3_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_SIZE_4      = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [3:0] AXI_CACHE_DEF   = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEF    = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA
    } state_e;

endpackage

// File: rtl/axi3_master_if.sv
// Fabric request bus plus AXI3 master port bundle.
// The master modport is the bridge's view.
interface axi3_master_if #(
    parameter int IDW = 6
);
    logic            inreq;
    logic            inwr;
    logic [31:0]     inaddr;
    logic [31:0]     inwdata;
    logic [3:0]      inwstrb;
    logic            inack;
    logic            inerr;
    logic [31:0]     inrdata;

    logic            axiawvalid;
    logic            axiawready;
    logic [31:0]     axiawaddr;
    logic [3:0]      axiawlen;
    logic [1:0]      axiawsize;
    logic [1:0]      axiawburst;
    logic [1:0]      axiawlock;
    logic [3:0]      axiawcache;
    logic [2:0]      axiawprot;
    logic [3:0]      axiawqos;
    logic [IDW-1:0]  axiawid;

    logic            axiwvalid;
    logic            axiwready;
    logic [31:0]     axiwdata;
    logic [3:0]      axiwstrb;
    logic            axiwlast;
    logic [IDW-1:0]  axiwid;

    logic            axibvalid;
    logic            axibready;
    logic [1:0]      axibresp;
    logic [IDW-1:0]  axibid;

    logic            axiarvalid;
    logic            axiarready;
    logic [31:0]     axiaraddr;
    logic [3:0]      axiarlen;
    logic [1:0]      axiarsize;
    logic [1:0]      axiarburst;
    logic [1:0]      axiarlock;
    logic [3:0]      axiarcache;
    logic [2:0]      axiarprot;
    logic [3:0]      axiarqos;
    logic [IDW-1:0]  axiarid;

    logic            axirvalid;
    logic            axirready;
    logic [31:0]     axirdata;
    logic [1:0]      axirresp;
    logic            axirlast;
    logic [IDW-1:0]  axirid;

    modport master (
        input  inreq, inwr, inaddr, inwdata, inwstrb,
        output inack, inerr, inrdata,
        output axiawvalid, axiawaddr, axiawlen, axiawsize, axiawburst,
        output axiawlock, axiawcache, axiawprot, axiawqos, axiawid,
        input  axiawready,
        output axiwvalid, axiwdata, axiwstrb, axiwlast, axiwid,
        input  axiwready,
        input  axibvalid, axibresp, axibid,
        output axibready,
        output axiarvalid, axiaraddr, axiarlen, axiarsize, axiarburst,
        output axiarlock, axiarcache, axiarprot, axiarqos, axiarid,
        input  axiarready,
        input  axirvalid, axirdata, axirresp, axirlast, axirid,
        output axirready
    );

    modport slave (
        output inreq, inwr, inaddr, inwdata, inwstrb,
        input  inack, inerr, inrdata,
        input  axiawvalid, axiawaddr, axiawlen, axiawsize, axiawburst,
        input  axiawlock, axiawcache, axiawprot, axiawqos, axiawid,
        output axiawready,
        input  axiwvalid, axiwdata, axiwstrb, axiwlast, axiwid,
        output axiwready,
        output axibvalid, axibresp, axibid,
        input  axibready,
        input  axiarvalid, axiaraddr, axiarlen, axiarsize, axiarburst,
        input  axiarlock, axiarcache, axiarprot, axiarqos, axiarid,
        output axiarready,
        output axirvalid, axirdata, axirresp, axirlast, axirid,
        input  axirready
    );
endinterface

// File: rtl/axi3_master.sv
// Single-outstanding bridge from the one-word request bus
// to an AXI3 master port (single-beat INCR transfers).
module axi3_master
    import axi3_master_pkg::*;
#(
    parameter int IDW = 6,
    parameter int ID  = 0
) (
    input  logic          clk,
    input  logic          rstn,
    axi3_master_if.master bus
);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        arvalid_q;
    logic        bready_q;
    logic        rready_q;
    logic        inack_q;
    logic        inerr_q;
    logic [31:0] inrdata_q;

    logic awdone;
    logic wdone;
    logic unused_ok;

    // A channel is done if its handshake is past or happens now.
    assign awdone = !awvalid_q || bus.axiawready;
    assign wdone  = !wvalid_q || bus.axiwready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            inack_q   <= 1'b0;
            inerr_q   <= 1'b0;
            inrdata_q <= '0;
        end else begin
            inack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.inreq) begin
                        addr_q  <= {bus.inaddr[31:2], 2'b00};
                        wdata_q <= bus.inwdata;
                        wstrb_q <= bus.inwstrb;
                        if (bus.inwr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    if (awvalid_q && bus.axiawready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && bus.axiwready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (awdone && wdone) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (bus.axibvalid) begin
                        bready_q <= 1'b0;
                        inack_q  <= 1'b1;
                        inerr_q  <= bus.axibresp[1];
                        state_q  <= S_IDLE;
                    end
                end
                S_RADDR: begin
                    if (bus.axiarready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    // Non-last beats are accepted and dropped.
                    if (bus.axirvalid && bus.axirlast) begin
                        rready_q  <= 1'b0;
                        inack_q   <= 1'b1;
                        inerr_q   <= bus.axirresp[1];
                        inrdata_q <= bus.axirdata;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.inack   = inack_q;
    assign bus.inerr   = inerr_q;
    assign bus.inrdata = inrdata_q;

    assign bus.axiawvalid = awvalid_q;
    assign bus.axiawaddr  = addr_q;
    assign bus.axiawlen   = 4'd0;
    assign bus.axiawsize  = AXI_SIZE_4;
    assign bus.axiawburst = AXI_BURST_INCR;
    assign bus.axiawlock  = 2'b00;
    assign bus.axiawcache = AXI_CACHE_DEF;
    assign bus.axiawprot  = AXI_PROT_DEF;
    assign bus.axiawqos   = 4'd0;
    assign bus.axiawid    = IDW'(ID);

    assign bus.axiwvalid = wvalid_q;
    assign bus.axiwdata  = wdata_q;
    assign bus.axiwstrb  = wstrb_q;
    assign bus.axiwlast  = wvalid_q;
    assign bus.axiwid    = IDW'(ID);

    assign bus.axibready = bready_q;

    assign bus.axiarvalid = arvalid_q;
    assign bus.axiaraddr  = addr_q;
    assign bus.axiarlen   = 4'd0;
    assign bus.axiarsize  = AXI_SIZE_4;
    assign bus.axiarburst = AXI_BURST_INCR;
    assign bus.axiarlock  = 2'b00;
    assign bus.axiarcache = AXI_CACHE_DEF;
    assign bus.axiarprot  = AXI_PROT_DEF;
    assign bus.axiarqos   = 4'd0;
    assign bus.axiarid    = IDW'(ID);

    assign bus.axirready = rready_q;

    // Response IDs and the low resp bit carry no information here.
    assign unused_ok = ^{bus.axibid, bus.axirid,
                         bus.axibresp[0], bus.axirresp[0]};

endmodule

// File: tb/tb_axi3_master.sv
// Directed table-driven bench for axi3_master with an
// in-line cycle-level AXI slave responder.
module tb_axi3_master;

    logic clk;
    logic rstn;
    int   nchk;
    int   nerr;

    axi3_master_if #(.IDW(6)) bus ();

    axi3_master #(.IDW(6), .ID(0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          nstray;
        int          busy_c;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        bit          exp_err;
        int          lat;
        bit          b2b;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        bus.axiawready = 1'b0;
        bus.axiwready  = 1'b0;
        bus.axibvalid  = 1'b0;
        bus.axibresp   = 2'b00;
        bus.axibid     = 6'h2A;
        bus.axiarready = 1'b0;
        bus.axirvalid  = 1'b0;
        bus.axirdata   = 32'h0;
        bus.axirresp   = 2'b00;
        bus.axirlast   = 1'b0;
        bus.axirid     = 6'h15;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_flags"},
            {bus.inack, bus.inerr, bus.axiawvalid, bus.axiwvalid,
             bus.axiarvalid, bus.axibready, bus.axirready,
             bus.axiwlast}, 64'd0);
        chk({tag, "_inrdata"}, bus.inrdata, 64'd0);
        chk({tag, "_awaddr"}, bus.axiawaddr, 64'd0);
        chk({tag, "_araddr"}, bus.axiaraddr, 64'd0);
        chk({tag, "_wdata"}, {bus.axiwdata, bus.axiwstrb}, 64'd0);
    endtask

    task automatic issue(input vec_t v);
        bus.inreq   = 1'b1;
        bus.inwr    = v.wr;
        bus.inaddr  = v.addr;
        bus.inwdata = v.wdata;
        bus.inwstrb = v.wstrb;
        @(posedge clk);
        #1 bus.inreq = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input vec_t nx,
                           input bit issued);
        int acks;
        int ack_c;
        int bi;
        bit awv_p, awhs_p, wv_p, whs_p, rhs_p;
        bit aw_seen, w_seen;
        logic [31:0] awa_p, wd_p;
        logic [3:0]  ws_p;
        acks = 0; ack_c = 0; bi = 0;
        awv_p = 0; awhs_p = 0; wv_p = 0; whs_p = 0; rhs_p = 0;
        aw_seen = 0; w_seen = 0;
        awa_p = '0; wd_p = '0; ws_p = '0;
        if (!issued) begin
            @(negedge clk);
            issue(v);
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rhs_p) bi++;
            if (awhs_p) aw_seen = 1;
            if (whs_p) w_seen = 1;
            if (c == 1)
                chk("valid_rise",
                    {bus.axiawvalid, bus.axiwvalid, bus.axiarvalid},
                    v.wr ? 64'd6 : 64'd1);
            if (awhs_p)
                chk("aw_drop", bus.axiawvalid, 64'd0);
            else if (awv_p)
                chk("aw_hold", {bus.axiawvalid, bus.axiawaddr},
                    {1'b1, awa_p});
            if (whs_p)
                chk("w_drop", bus.axiwvalid, 64'd0);
            else if (wv_p)
                chk("w_hold",
                    {bus.axiwvalid, bus.axiwdata, bus.axiwstrb},
                    {1'b1, wd_p, ws_p});
            if (bus.axiawvalid) begin
                chk("awaddr", bus.axiawaddr, v.exp_addr);
                chk("aw_const",
                    {bus.axiawlen, bus.axiawsize, bus.axiawburst,
                     bus.axiawlock, bus.axiawcache, bus.axiawprot,
                     bus.axiawqos, bus.axiawid},
                    {4'd0, 2'b10, 2'b01, 2'b00, 4'b0011, 3'b000,
                     4'd0, 6'd0});
            end
            if (bus.axiwvalid)
                chk("w_payload",
                    {bus.axiwdata, bus.axiwstrb, bus.axiwlast,
                     bus.axiwid},
                    {v.wdata, v.wstrb, 1'b1, 6'd0});
            if (bus.axiarvalid) begin
                chk("araddr", bus.axiaraddr, v.exp_addr);
                chk("ar_const",
                    {bus.axiarlen, bus.axiarsize, bus.axiarburst,
                     bus.axiarlock, bus.axiarcache, bus.axiarprot,
                     bus.axiarqos, bus.axiarid},
                    {4'd0, 2'b10, 2'b01, 2'b00, 4'b0011, 3'b000,
                     4'd0, 6'd0});
            end
            if (bus.axibready)
                chk("b_after_both",
                    {bus.axiawvalid, bus.axiwvalid, aw_seen, w_seen},
                    64'h3);
            if (v.wr)
                chk("cross_chan", {bus.axiarvalid, bus.axirready},
                    64'd0);
            else
                chk("cross_chan",
                    {bus.axiawvalid, bus.axiwvalid, bus.axibready},
                    64'd0);
            if (bus.inack) begin
                acks++;
                if (acks == 1) begin
                    ack_c = c;
                    chk("latency", c, v.lat);
                    chk("inerr", bus.inerr, v.exp_err);
                    if (!v.wr) chk("inrdata", bus.inrdata, v.rdata);
                end
            end
            bus.inreq = (c == v.busy_c);
            if (c == v.busy_c) begin
                bus.inwr   = 1'b0;
                bus.inaddr = 32'h7000_0000;
            end
            bus.axiawready = bus.axiawvalid && (c > v.aw_dly);
            bus.axiwready  = bus.axiwvalid && (c > v.w_dly);
            bus.axibvalid  = bus.axibready && (c > v.b_dly);
            bus.axibresp   = v.resp;
            bus.axiarready = bus.axiarvalid && (c > v.ar_dly);
            bus.axirvalid  = bus.axirready;
            bus.axirlast   = (bi == v.nstray);
            bus.axirdata   = (bi < v.nstray) ? 32'hAAAA_AAAA : v.rdata;
            bus.axirresp   = (bi < v.nstray) ? 2'b00 : v.resp;
            awv_p  = bus.axiawvalid;
            awhs_p = bus.axiawvalid && bus.axiawready;
            awa_p  = bus.axiawaddr;
            wv_p   = bus.axiwvalid;
            whs_p  = bus.axiwvalid && bus.axiwready;
            wd_p   = bus.axiwdata;
            ws_p   = bus.axiwstrb;
            rhs_p  = bus.axirvalid && bus.axirready;
            if (bus.inack && v.b2b) begin
                issue(nx);
                break;
            end
            if (acks > 0 && c >= ack_c + 2) break;
        end
        slave_idle();
        chk("ack_count", acks, 1);
    endtask

    vec_t v0;

    initial begin
        nchk = 0;
        nerr = 0;
        rstn = 1'b0;
        bus.inreq   = 1'b0;
        bus.inwr    = 1'b0;
        bus.inaddr  = '0;
        bus.inwdata = '0;
        bus.inwstrb = '0;
        slave_idle();

        // wr addr wdata strb awd wd bd ard nstr busy resp rdata exp err lat b2b
        tbl[0] = '{1, 32'h1000_0007, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0,
                   2'b00, 32'h0, 32'h1000_0004, 0, 3, 1};
        tbl[1] = '{0, 32'h2000_0000, 32'h0, 4'h0, 0, 0, 0, 3, 0, 0,
                   2'b10, 32'h1234_5678, 32'h2000_0000, 1, 6, 0};
        tbl[2] = '{1, 32'h3000_0010, 32'h0BAD_F00D, 4'h3, 5, 0, 0, 0, 0, 0,
                   2'b00, 32'h0, 32'h3000_0010, 0, 8, 0};
        tbl[3] = '{1, 32'h3000_0022, 32'h1357_9BDF, 4'hC, 0, 2, 0, 0, 0, 0,
                   2'b11, 32'h0, 32'h3000_0020, 1, 5, 0};
        tbl[4] = '{0, 32'h4000_0003, 32'h0, 4'h0, 0, 0, 0, 0, 1, 0,
                   2'b00, 32'h5555_5555, 32'h4000_0000, 0, 4, 0};
        tbl[5] = '{1, 32'h0000_0100, 32'h0000_0001, 4'h8, 0, 0, 4, 0, 0, 3,
                   2'b00, 32'h0, 32'h0000_0100, 0, 6, 0};
        tbl[6] = '{0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
                   2'b00, 32'hCAFE_F00D, 32'h0000_0008, 0, 3, 0};

        #12;
        check_reset("rst0");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++)
            run_txn(tbl[i], tbl[(i + 1) % NV], i > 0 && tbl[i - 1].b2b);

        // Abort a read while waiting for its data.
        @(negedge clk);
        bus.inreq  = 1'b1;
        bus.inwr   = 1'b0;
        bus.inaddr = 32'h6000_0000;
        @(posedge clk);
        #1 bus.inreq = 1'b0;
        @(negedge clk);
        bus.axiarready = 1'b1;
        @(posedge clk);
        #1 bus.axiarready = 1'b0;
        @(negedge clk);
        chk("rdata_state", {bus.axirready, bus.axiarvalid}, 64'h2);
        #2 rstn = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        check_reset("rst_hold");
        rstn = 1'b1;

        v0 = tbl[0];
        v0.b2b = 0;
        run_txn(v0, v0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nerr);
        $finish;
    end

endmodule
